// File: rtl/vga_score_ctrl.sv
// vga_score_ctrl: two-player score keeper for the VGA scoreboard.
// Arbitrates point pulses, sequences rounds, updates digits on frame edges.
module vga_score_ctrl #(
    parameter int WIN_SCORE   = 9,
    parameter int HOLD_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pt0,
    input  logic       pt1,
    input  logic       vsync,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic       ack0,
    output logic       ack1,
    output logic [1:0] winner,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_WIN  = 2'b10
    } state_t;

    localparam logic [3:0] WIN_VAL  = 4'(WIN_SCORE);
    localparam logic [7:0] HOLD_VAL = 8'(HOLD_FRAMES);

    state_t     state_q, state_d;
    logic [3:0] cnt0_q, cnt0_d;
    logic [3:0] cnt1_q, cnt1_d;
    logic       pend0_q, pend0_d;
    logic       pend1_q, pend1_d;
    logic       last_q, last_d;
    logic       vs_q, vs_d;
    logic [7:0] fcnt_q, fcnt_d;
    logic [3:0] score0_q, score0_d;
    logic [3:0] score1_q, score1_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic [1:0] winner_q, winner_d;

    logic fe;
    logic req0, req1;
    logic gnt0, gnt1;

    // falling edge of the active-low vsync marks a frame boundary
    assign fe   = vs_q & ~vsync;
    assign req0 = pend0_q | pt0;
    assign req1 = pend1_q | pt1;

    // round sequencing, arbitration and score counters
    always_comb begin
        state_d  = state_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;
        pend0_d  = pend0_q;
        pend1_d  = pend1_q;
        last_d   = last_q;
        fcnt_d   = fcnt_q;
        winner_d = winner_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt0_d   = 4'd0;
                cnt1_d   = 4'd0;
                pend0_d  = 1'b0;
                pend1_d  = 1'b0;
                winner_d = 2'b00;
                if (start) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (start) begin
                    cnt0_d  = 4'd0;
                    cnt1_d  = 4'd0;
                    pend0_d = 1'b0;
                    pend1_d = 1'b0;
                end else begin
                    gnt0    = req0 & (~req1 | last_q);
                    gnt1    = req1 & (~req0 | ~last_q);
                    pend0_d = req0 & ~gnt0;
                    pend1_d = req1 & ~gnt1;
                    if (gnt0) begin
                        cnt0_d = cnt0_q + 4'd1;
                        ack0_d = 1'b1;
                        last_d = 1'b0;
                    end
                    if (gnt1) begin
                        cnt1_d = cnt1_q + 4'd1;
                        ack1_d = 1'b1;
                        last_d = 1'b1;
                    end
                    if ((gnt0 && cnt0_d == WIN_VAL) ||
                        (gnt1 && cnt1_d == WIN_VAL)) begin
                        state_d  = S_WIN;
                        winner_d = gnt0 ? 2'b01 : 2'b10;
                        pend0_d  = 1'b0;
                        pend1_d  = 1'b0;
                        fcnt_d   = 8'd0;
                    end
                end
            end
            S_WIN: begin
                if (fcnt_q == HOLD_VAL) begin
                    state_d  = S_IDLE;
                    cnt0_d   = 4'd0;
                    cnt1_d   = 4'd0;
                    winner_d = 2'b00;
                end else if (fe) begin
                    fcnt_d = fcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // display digits change only on a frame edge; winner flashes in WIN
    always_comb begin
        vs_d     = vsync;
        score0_d = score0_q;
        score1_d = score1_q;
        if (fe) begin
            score0_d = cnt0_q;
            score1_d = cnt1_q;
            if (state_q == S_WIN && fcnt_q[4]) begin
                if (winner_q == 2'b01) begin
                    score0_d = 4'hF;
                end
                if (winner_q == 2'b10) begin
                    score1_d = 4'hF;
                end
            end
        end
    end

    // state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt0_q   <= 4'd0;
            cnt1_q   <= 4'd0;
            pend0_q  <= 1'b0;
            pend1_q  <= 1'b0;
            last_q   <= 1'b1;
            vs_q     <= 1'b1;
            fcnt_q   <= 8'd0;
            score0_q <= 4'd0;
            score1_q <= 4'd0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            winner_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
            pend0_q  <= pend0_d;
            pend1_q  <= pend1_d;
            last_q   <= last_d;
            vs_q     <= vs_d;
            fcnt_q   <= fcnt_d;
            score0_q <= score0_d;
            score1_q <= score1_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            winner_q <= winner_d;
        end
    end

    assign score0 = score0_q;
    assign score1 = score1_q;
    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign winner = winner_q;
    assign state  = state_q;

endmodule
